wb_deserializer: RTL and testbench
==================================

# wb_deserializer

Receive-side counterpart of the Wishbone serializer. It samples a one-bit serial stream qualified by an enable strobe and reassembles 27-bit packets, each made of three 9-bit `{k, 8-bit}` symbols. Completed packets are buffered in a 4-entry FIFO, and a Wishbone master reads them through registered, single-cycle-acknowledged accesses. The block sits at the far end of the serial link, or in loopback directly on the serializer's `data_o`/`ena_o`.

## Interface
- `FIFO_DEPTH`, 4: packet buffer entries; must be a power of 2.
- `PKT_BITS`, 27: bits per packet (three 9-bit symbols).
- `CLK_I` in, 1: clock; all logic is on the rising edge.
- `RST_I` in, 1: synchronous, active-low reset.
- `data_i` in, 1: serial data bit, MSB of the packet first.
- `ena_i` in, 1: `data_i` is valid in this cycle.
- `irq_o` out, 1: FIFO non-empty.
- `CYC_I` in, 1: Wishbone cycle.
- `STB_I` in, 1: Wishbone strobe.
- `WE_I` in, 1: write enable.
- `ADR_I` in, 32: address; only the low `$bits(NUM_REGS)` bits are decoded.
- `DAT_I` in, 32: write data.
- `ACK_O` out, 1: acknowledge.
- `ERR_O` out, 1: error.
- `DAT_O` out, 32: read data.

## Operation
- **Receiver FSM** has two states, IDLE and SHIFT. It keeps a 5-bit bit counter `bcnt` and a 27-bit shift register `shreg`.
  - IDLE with `ena_i=1`: shift in the bit, set `bcnt=1`, go to SHIFT.
  - SHIFT with `ena_i=1`: shift in the bit and increment `bcnt`.
  - When bit 27 is shifted in: push `{5'b0, shreg}` to the FIFO, clear `bcnt`, go to IDLE.
  - Back-to-back packets are allowed. If `ena_i` stays high, the next cycle's bit starts a new packet.
  - SHIFT with `ena_i=0` and `bcnt` in 1..26: discard the partial packet, set sticky `frame_err`, go to IDLE.
- **FIFO**:
  - A push into a full FIFO is dropped and sets sticky `overflow`.
  - A push and a pop in the same cycle on a full FIFO are both accepted.
  - Read and write pointers wrap modulo `FIFO_DEPTH`. `count` ranges 0..`FIFO_DEPTH`.
- **Register map** (`ADR_RXDATA`=0, `ADR_STATUS`=1):
  - Read `ADR_RXDATA`: returns the FIFO head and pops it.
  - Read `ADR_RXDATA` with the FIFO empty: `ERR_O`, no pop, `DAT_O`=0.
  - Write `ADR_RXDATA`: `ERR_O`.
  - Read `ADR_STATUS`: `[0]` empty, `[1]` full, `[2]` overflow, `[3]` frame_err, `[6:4]` count, `[31:7]`=0.
  - Write `ADR_STATUS`: `DAT_I[2]=1` clears overflow and `DAT_I[3]=1` clears frame_err. If a set and a clear land in the same cycle, the set wins.
  - Any other address: `ERR_O`.
- **Reset values**:
  - `ACK_O=0`, `ERR_O=0`, `DAT_O=0`, `irq_o=0`.
  - FIFO empty, flags cleared, FSM in IDLE.
  - Reset mid-packet or mid-access aborts it with no side effects after release.

## Timing
- **Serial receive latency**: the last bit is sampled at edge N, the FIFO write happens at edge N+1, and `irq_o` and `empty=0` are visible after edge N+1.
- **Wishbone request**: a request is `CYC_I & STB_I` sampled while `ACK_O` and `ERR_O` are both low.
  - On the next edge the block registers exactly one of `ACK_O`/`ERR_O` high for one cycle, with `DAT_O` valid in that same cycle.
  - The pop and any flag clear take effect on that same edge.
- **DAT_O hold**: `DAT_O` holds its value until the next response.
- **Request rate**: at most one response per two cycles. A master that holds `STB_I` high receives a new response every other cycle.

## Structure
- **Package `WBDeserializer`**:
  - `NUM_REGS`, `ADR_RXDATA`, `ADR_STATUS`, `PKT_BITS`.
  - Status bit indices.
  - An `rx_state_t` enum {IDLE, SHIFT}.
- **Sub-module `deserializer_out`**:
  - Contains the receiver FSM, `shreg` and `bcnt`.
  - Outputs: `pkt_o[26:0]`, `pkt_valid_o` (1 cycle) and `frame_err_o` (1 cycle).
- **Top level**: contains the FIFO, the sticky flags and the Wishbone decode.

## Test plan
- **Single packet**: shift 27'h5A5_A5A5 MSB-first with `ena_i` high for 27 cycles, then read `ADR_RXDATA` → `irq_o` high one cycle after the last bit; ACK with `DAT_O`=32'h05A5_A5A5; `irq_o` low after the pop.
- **Back-to-back**: send two packets, 27'h100_0001 and 27'h0FF_00FF, with `ena_i` high for 54 cycles → status count=2, then reads return them in order.
- **Framing error**: drop `ena_i` after 13 bits, then send one full packet → frame_err=1, FIFO holds only the full packet, and writing 32'h8 to `ADR_STATUS` clears frame_err.
- **Overflow**: send 5 packets with no reads → full=1, overflow=1, count=4; the first four are read back intact and the fifth is lost.
- **Error responses**: read `ADR_RXDATA` with the FIFO empty, write `ADR_RXDATA`, access address 2 → `ERR_O` pulse each time, `ACK_O`=0, FIFO unchanged.
- **Reset and simultaneous push/pop**: pull `RST_I` low mid-packet (bit 10), release, then send a full packet → only the full packet is stored. With the FIFO full, a read ACK coinciding with packet completion leaves count=4 and overflow=0.

Source files
------------

// File: rtl/wb_deserializer_pkg.sv
// Shared constants and types for the Wishbone serial receiver.
// Register map, status bit positions and receiver state encoding.
package WBDeserializer;

    localparam logic [1:0] NUM_REGS = 2'd2;
    localparam int ADR_W = $bits(NUM_REGS);

    localparam logic [ADR_W-1:0] ADR_RXDATA = 2'd0;
    localparam logic [ADR_W-1:0] ADR_STATUS = 2'd1;

    localparam int PKT_BITS = 27;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LO  = 4;
    localparam int ST_COUNT_HI  = 6;

    typedef enum logic {
        IDLE,
        SHIFT
    } rx_state_t;

endpackage

// File: rtl/wb_deserializer_out.sv
// Serial receiver: shifts enabled bits MSB-first into a packet.
// Emits one-cycle strobes for a completed packet or a broken frame.
module deserializer_out #(
    parameter int PKT_BITS = 27
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                data_i,
    input  logic                ena_i,
    output logic [PKT_BITS-1:0] pkt_o,
    output logic                pkt_valid_o,
    output logic                frame_err_o
);
    import WBDeserializer::*;

    localparam logic [4:0] LAST = 5'(PKT_BITS - 1);

    rx_state_t           state_q;
    rx_state_t           state_d;
    logic [4:0]          bcnt_q;
    logic [PKT_BITS-1:0] shreg_q;
    logic                done;
    logic                ferr;

    // State register
    always_ff @(posedge CLK_I) begin
        if (!RST_I) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: leave SHIFT on the final bit or on a gap in ena_i
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (ena_i) state_d = SHIFT;
            SHIFT: if (!ena_i || bcnt_q == LAST) state_d = IDLE;
        endcase
    end

    // Outputs: packet completion and frame break detection
    always_comb begin
        done = (state_q == SHIFT) && ena_i && (bcnt_q == LAST);
        ferr = (state_q == SHIFT) && !ena_i;
    end

    // Datapath: shift register, bit counter and registered strobes
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            shreg_q     <= '0;
            bcnt_q      <= '0;
            pkt_valid_o <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            pkt_valid_o <= done;
            frame_err_o <= ferr;
            if (ena_i) shreg_q <= {shreg_q[PKT_BITS-2:0], data_i};
            if (done || ferr) bcnt_q <= '0;
            else if (ena_i)   bcnt_q <= bcnt_q + 5'd1;
        end
    end

    assign pkt_o = shreg_q;

endmodule

// File: rtl/wb_deserializer.sv
// Wishbone-readable packet receiver with a small packet FIFO.
// Sticky overflow/frame flags are cleared by writing the status register.
module wb_deserializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int PKT_BITS   = 27
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        data_i,
    input  logic        ena_i,
    output logic        irq_o,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic [31:0] DAT_O
);
    import WBDeserializer::*;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [PKT_BITS-1:0] pkt;
    logic                pkt_valid;
    logic                ferr_pulse;

    logic [PKT_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                overflow;
    logic                frame_err;

    logic                empty;
    logic                full;
    logic                req;
    logic [ADR_W-1:0]    adr;
    logic [31:0]         status;
    logic                ack_d;
    logic                err_d;
    logic [31:0]         dat_d;
    logic                pop;
    logic                push_ok;
    logic                ov_set;
    logic                clr_ov;
    logic                clr_fe;
    logic                unused_ok;

    deserializer_out #(.PKT_BITS(PKT_BITS)) u_rx (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .data_i      (data_i),
        .ena_i       (ena_i),
        .pkt_o       (pkt),
        .pkt_valid_o (pkt_valid),
        .frame_err_o (ferr_pulse)
    );

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign irq_o = !empty;
    assign req   = CYC_I && STB_I && !ACK_O && !ERR_O;
    assign adr   = ADR_I[ADR_W-1:0];

    assign unused_ok = ^{ADR_I[31:ADR_W], DAT_I[31:4], DAT_I[1:0]};

    // A push into a full FIFO still lands if a pop frees a slot
    assign push_ok = pkt_valid && (!full || pop);
    assign ov_set  = pkt_valid && full && !pop;

    // Status word assembly
    always_comb begin
        status = '0;
        status[ST_EMPTY]     = empty;
        status[ST_FULL]      = full;
        status[ST_OVERFLOW]  = overflow;
        status[ST_FRAME_ERR] = frame_err;
        status[ST_COUNT_HI:ST_COUNT_LO] = 3'(count);
    end

    // Wishbone decode: pick the response, read data and side effects
    always_comb begin
        ack_d  = 1'b0;
        err_d  = 1'b0;
        dat_d  = '0;
        pop    = 1'b0;
        clr_ov = 1'b0;
        clr_fe = 1'b0;
        if (req) begin
            unique case (1'b1)
                (adr == ADR_RXDATA) && !WE_I && !empty: begin
                    ack_d = 1'b1;
                    pop   = 1'b1;
                    dat_d = 32'(mem[rd_ptr]);
                end
                (adr == ADR_STATUS) && !WE_I: begin
                    ack_d = 1'b1;
                    dat_d = status;
                end
                (adr == ADR_STATUS) && WE_I: begin
                    ack_d  = 1'b1;
                    clr_ov = DAT_I[ST_OVERFLOW];
                    clr_fe = DAT_I[ST_FRAME_ERR];
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates reads
    always_ff @(posedge CLK_I) begin
        if (push_ok) mem[wr_ptr] <= pkt;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    // Sticky flags; a set beats a clear in the same cycle
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ov_set)      overflow  <= 1'b1;
            else if (clr_ov) overflow  <= 1'b0;
            if (ferr_pulse)  frame_err <= 1'b1;
            else if (clr_fe) frame_err <= 1'b0;
        end
    end

    // Registered one-cycle response; DAT_O holds between responses
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
            DAT_O <= '0;
        end else begin
            ACK_O <= ack_d;
            ERR_O <= err_d;
            if (ack_d || err_d) DAT_O <= dat_d;
        end
    end

endmodule

// File: tb/tb_wb_deserializer.sv
// Self-checking bench for wb_deserializer.
// Packets and flags are tracked by a queue-based reference model.
module tb_wb_deserializer;

    logic        CLK_I  = 1'b0;
    logic        RST_I  = 1'b0;
    logic        data_i = 1'b0;
    logic        ena_i  = 1'b0;
    logic        CYC_I  = 1'b0;
    logic        STB_I  = 1'b0;
    logic        WE_I   = 1'b0;
    logic [31:0] ADR_I  = '0;
    logic [31:0] DAT_I  = '0;
    logic        irq_o;
    logic        ACK_O;
    logic        ERR_O;
    logic [31:0] DAT_O;

    int total = 0;
    int bad   = 0;

    logic [26:0] q[$];
    bit          m_ov = 0;
    bit          m_fe = 0;

    wb_deserializer dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .data_i (data_i),
        .ena_i  (ena_i),
        .irq_o  (irq_o),
        .CYC_I  (CYC_I),
        .STB_I  (STB_I),
        .WE_I   (WE_I),
        .ADR_I  (ADR_I),
        .DAT_I  (DAT_I),
        .ACK_O  (ACK_O),
        .ERR_O  (ERR_O),
        .DAT_O  (DAT_O)
    );

    always #5 CLK_I = ~CLK_I;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[0]   = (q.size() == 0);
        s[1]   = (q.size() == 4);
        s[2]   = m_ov;
        s[3]   = m_fe;
        s[6:4] = 3'(q.size());
        return s;
    endfunction

    task automatic shift_bits(input logic [26:0] p, input int n);
        for (int i = 26; i > 26 - n; i--) begin
            @(negedge CLK_I);
            data_i = p[i];
            ena_i  = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_I);
            ena_i  = 1'b0;
            data_i = 1'b0;
        end
    endtask

    task automatic send_pkt(input logic [26:0] p);
        shift_bits(p, 27);
        if (q.size() == 4) m_ov = 1;
        else q.push_back(p);
    endtask

    task automatic wb(input bit we, input logic [31:0] adr,
                      input logic [31:0] dat, output bit ack,
                      output bit err, output logic [31:0] rd);
        @(negedge CLK_I);
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = we;
        ADR_I = adr;
        DAT_I = dat;
        @(negedge CLK_I);
        ack   = ACK_O;
        err   = ERR_O;
        rd    = DAT_O;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
    endtask

    task automatic test_reset();
        bit ack, err;
        logic [31:0] rd, exp;
        RST_I = 1'b0;
        repeat (3) @(negedge CLK_I);
        total++;
        if ({ACK_O, ERR_O, irq_o} !== 3'b000 || DAT_O !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs ack/err/irq=%b%b%b dat=%h want 000/0",
                     ACK_O, ERR_O, irq_o, DAT_O);
        end
        RST_I = 1'b1;
        q.delete(); m_ov = 0; m_fe = 0;
        wb(0, 32'd1, 0, ack, err, rd);
        exp = exp_status();
        total++;
        if (!ack || rd !== exp) begin
            bad++;
            $display("FAIL reset_status ack=%0d got=%h want=%h", ack, rd, exp);
        end
    endtask

    task automatic test_single();
        bit ack, err;
        logic [31:0] rd;
        shift_bits(27'h5A5_A5A5, 27);
        @(negedge CLK_I);
        ena_i = 1'b0;
        total++;
        if (irq_o !== 1'b0) begin
            bad++;
            $display("FAIL single_irq_early got=%b want=0", irq_o);
        end
        @(negedge CLK_I);
        total++;
        if (irq_o !== 1'b1) begin
            bad++;
            $display("FAIL single_irq_latency got=%b want=1", irq_o);
        end
        q.push_back(27'h5A5_A5A5);
        wb(0, 32'd0, 0, ack, err, rd);
        void'(q.pop_front());
        total++;
        if (!ack || err || rd !== 32'h05A5_A5A5) begin
            bad++;
            $display("FAIL single_read ack=%0d err=%0d got=%h want=05a5a5a5",
                     ack, err, rd);
        end
        total++;
        if (irq_o !== 1'b0) begin
            bad++;
            $display("FAIL single_irq_after_pop got=%b want=0", irq_o);
        end
    endtask

    task automatic drain(input string tag);
        bit ack, err;
        logic [31:0] rd, exp;
        while (q.size() > 0) begin
            exp = {5'b0, q.pop_front()};
            wb(0, 32'd0, 0, ack, err, rd);
            total++;
            if (!ack || err || rd !== exp) begin
                bad++;
                $display("FAIL %s_read ack=%0d err=%0d got=%h want=%h",
                         tag, ack, err, rd, exp);
            end
        end
    endtask

    task automatic check_status(input string tag);
        bit ack, err;
        logic [31:0] rd, exp;
        wb(0, 32'd1, 0, ack, err, rd);
        exp = exp_status();
        total++;
        if (!ack || err || rd !== exp) begin
            bad++;
            $display("FAIL %s_status ack=%0d err=%0d got=%h want=%h",
                     tag, ack, err, rd, exp);
        end
    endtask

    task automatic test_back_to_back();
        send_pkt(27'h100_0001);
        send_pkt(27'h0FF_00FF);
        idle(2);
        check_status("b2b");
        drain("b2b");
    endtask

    task automatic test_frame_err();
        bit ack, err;
        logic [31:0] rd;
        shift_bits(27'($urandom), 13);
        idle(1);
        m_fe = 1;
        send_pkt(27'($urandom));
        idle(2);
        check_status("ferr");
        drain("ferr");
        wb(1, 32'd1, 32'h8, ack, err, rd);
        m_fe = 0;
        check_status("ferr_clear");
    endtask

    task automatic test_overflow();
        bit ack, err;
        logic [31:0] rd;
        for (int i = 0; i < 5; i++) send_pkt(27'($urandom));
        idle(2);
        check_status("ovf");
        drain("ovf");
        check_status("ovf_empty");
        wb(1, 32'd1, 32'h4, ack, err, rd);
        m_ov = 0;
        check_status("ovf_clear");
    endtask

    task automatic test_errors();
        bit ack, err;
        logic [31:0] rd;
        wb(0, 32'd0, 0, ack, err, rd);
        total++;
        if (ack || !err || rd !== 32'h0) begin
            bad++;
            $display("FAIL err_empty_read ack=%0d err=%0d dat=%h want 0/1/0",
                     ack, err, rd);
        end
        wb(1, 32'd0, 32'hFFFF_FFFF, ack, err, rd);
        total++;
        if (ack || !err) begin
            bad++;
            $display("FAIL err_write_rx ack=%0d err=%0d want 0/1", ack, err);
        end
        wb(0, 32'd2, 0, ack, err, rd);
        total++;
        if (ack || !err) begin
            bad++;
            $display("FAIL err_adr2 ack=%0d err=%0d want 0/1", ack, err);
        end
        wb(1, 32'd3, 32'hC, ack, err, rd);
        total++;
        if (ack || !err) begin
            bad++;
            $display("FAIL err_adr3 ack=%0d err=%0d want 0/1", ack, err);
        end
        check_status("err");
    endtask

    task automatic test_reset_mid();
        shift_bits(27'($urandom), 10);
        @(negedge CLK_I);
        RST_I = 1'b0;
        ena_i = 1'b0;
        @(negedge CLK_I);
        RST_I = 1'b1;
        q.delete(); m_ov = 0; m_fe = 0;
        send_pkt(27'($urandom));
        idle(2);
        check_status("rstmid");
        drain("rstmid");
    endtask

    task automatic test_push_pop_full();
        logic [26:0] p5;
        logic [31:0] exp;
        bit ack;
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) send_pkt(27'($urandom));
        p5 = 27'($urandom);
        shift_bits(p5, 27);
        @(negedge CLK_I);
        ena_i = 1'b0;
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b0;
        ADR_I = 32'd0;
        @(negedge CLK_I);
        ack   = ACK_O;
        rd    = DAT_O;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        exp = {5'b0, q.pop_front()};
        q.push_back(p5);
        total++;
        if (!ack || rd !== exp) begin
            bad++;
            $display("FAIL pushpop_read ack=%0d got=%h want=%h", ack, rd, exp);
        end
        check_status("pushpop");
        drain("pushpop");
    endtask

    task automatic test_random();
        bit ack, err;
        logic [31:0] rd, exp;
        wb(1, 32'd1, 32'hC, ack, err, rd);
        m_ov = 0; m_fe = 0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                send_pkt(27'($urandom));
                idle($urandom_range(1, 3));
            end else if (q.size() == 0) begin
                wb(0, 32'd0, 0, ack, err, rd);
                total++;
                if (ack || !err) begin
                    bad++;
                    $display("FAIL rand_empty it=%0d ack=%0d err=%0d", it, ack, err);
                end
            end else begin
                exp = {5'b0, q.pop_front()};
                wb(0, 32'd0, 0, ack, err, rd);
                total++;
                if (!ack || err || rd !== exp) begin
                    bad++;
                    $display("FAIL rand_read it=%0d got=%h want=%h", it, rd, exp);
                end
            end
        end
        check_status("rand");
        drain("rand");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_overflow();
        test_errors();
        test_reset_mid();
        test_push_pop_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
